// File: rtl/sc_rr_xbar_nxm_pkg.sv
// rtl/sc_rr_xbar_nxm_pkg.sv - shared types and elaboration helpers for the round-robin crossbar
// Purpose: input-side packet mode encoding plus constant functions used to
// validate the crossbar's width parameters at elaboration.
package sc_rr_xbar_nxm_pkg;

    // Per-input packet state: between packets, forwarding a locked packet,
    // or swallowing a packet whose first beat carried an illegal destination.
    typedef enum logic [1:0] {
        IN_IDLE = 2'd0,
        IN_FWD  = 2'd1,
        IN_DROP = 2'd2
    } in_mode_e;

    // Source-id width for n inputs; a single input still needs one bit.
    function automatic int src_w_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The destination field must be able to address every output.
    function automatic bit dest_w_ok(input int dest_w, input int n_out);
        return (2 ** dest_w) >= n_out;
    endfunction

endpackage

// File: rtl/sc_rr_xbar_nxm_arb.sv
// rtl/sc_rr_xbar_nxm_arb.sv - per-output round-robin arbiter with packet lock
// Purpose: grants one of N requesters, searching from the rr pointer; while a
// packet is in flight the grant is pinned to the owning requester.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   req        : per-requester request
//   lock       : a non-last beat from gnt_idx was accepted this cycle
//   advance    : a last beat from gnt_idx was accepted this cycle
//   gnt        : one-hot grant (zero when nobody eligible requests)
//   gnt_idx    : index of the granted requester
module sc_rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         lock,
    input  logic         advance,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    logic [W-1:0] ptr;
    logic         locked;
    logic [W-1:0] owner;

    always_comb begin
        int   idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        idx     = 0;
        found   = 1'b0;
        if (locked) begin
            // Owner keeps the output even when idle; nobody else may enter.
            gnt_idx    = owner;
            gnt[owner] = req[owner];
        end else begin
            for (int i = 0; i < N; i++) begin
                idx = int'(ptr) + i;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    gnt_idx  = W'(idx);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr    <= '0;
            locked <= 1'b0;
            owner  <= '0;
        end else if (advance) begin
            locked <= 1'b0;
            ptr    <= (gnt_idx == W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (lock) begin
            locked <= 1'b1;
            owner  <= gnt_idx;
        end
    end

endmodule

// File: rtl/sc_rr_xbar_nxm.sv
// rtl/sc_rr_xbar_nxm.sv - N_IN x N_OUT packet crossbar with per-output round-robin
// Purpose: routes packets from N_IN valid/ready inputs to N_OUT registered
// outputs. Each output locks to one input for the duration of a packet.
// Packets addressed past N_OUT are accepted, discarded and flagged on o_err.
// Ports:
//   i_clk, i_reset              : clock, synchronous active-high reset
//   i_valid/i_data/i_dest/i_last: per-input beat (i_dest used on first beat only)
//   o_ready                     : per-input accept
//   o_valid/o_data/o_last/o_src : per-output registered beat and its source index
//   i_ready                     : per-output downstream accept
//   o_err                       : sticky illegal-destination flag
module sc_rr_xbar_nxm
    import sc_rr_xbar_nxm_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 4,
    parameter int DATA_W = 32,
    parameter int DEST_W = 2,
    parameter int SRC_W  = 2
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [N_IN-1:0]         i_valid,
    input  logic [N_IN*DATA_W-1:0]  i_data,
    input  logic [N_IN*DEST_W-1:0]  i_dest,
    input  logic [N_IN-1:0]         i_last,
    output logic [N_IN-1:0]         o_ready,
    output logic [N_OUT-1:0]        o_valid,
    output logic [N_OUT*DATA_W-1:0] o_data,
    output logic [N_OUT-1:0]        o_last,
    output logic [N_OUT*SRC_W-1:0]  o_src,
    input  logic [N_OUT-1:0]        i_ready,
    output logic                    o_err
);

    if (!dest_w_ok(DEST_W, N_OUT)) begin : g_bad_dest_w
        $error("sc_rr_xbar_nxm: DEST_W too narrow for N_OUT");
    end
    if (SRC_W != src_w_of(N_IN)) begin : g_bad_src_w
        $error("sc_rr_xbar_nxm: SRC_W does not match N_IN");
    end

    in_mode_e          in_mode  [N_IN];
    logic [DEST_W-1:0] in_dest  [N_IN];
    logic [DEST_W-1:0] eff_dest [N_IN];
    logic [N_IN-1:0]   drop_now;
    logic [N_IN-1:0]   take_in;
    logic [N_IN-1:0]   req      [N_OUT];
    logic [N_IN-1:0]   gnt      [N_OUT];
    logic [SRC_W-1:0]  gnt_idx  [N_OUT];
    logic [N_OUT-1:0]  slot_free;
    logic [N_OUT-1:0]  take_out;
    logic [N_OUT-1:0]  take_last;

    // Destination in force for each input: stored while mid-packet, live otherwise.
    always_comb begin
        for (int k = 0; k < N_IN; k++) begin
            eff_dest[k] = (in_mode[k] == IN_FWD) ? in_dest[k] : i_dest[k*DEST_W +: DEST_W];
            case (in_mode[k])
                IN_DROP: drop_now[k] = 1'b1;
                IN_FWD:  drop_now[k] = 1'b0;
                default: drop_now[k] = (int'(eff_dest[k]) >= N_OUT);
            endcase
        end
    end

    // Request matrix; reset masks every request so nothing is accepted under reset.
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            for (int k = 0; k < N_IN; k++) begin
                req[j][k] = i_valid[k] & ~drop_now[k] & ~i_reset
                          & (eff_dest[k] == DEST_W'(j));
            end
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_arb
        sc_rr_arbiter #(
            .N (N_IN),
            .W (SRC_W)
        ) u_arb (
            .clk     (i_clk),
            .reset   (i_reset),
            .req     (req[j]),
            .lock    (take_out[j] & ~take_last[j]),
            .advance (take_out[j] & take_last[j]),
            .gnt     (gnt[j]),
            .gnt_idx (gnt_idx[j])
        );
    end

    always_comb begin
        o_ready = i_valid & drop_now & {N_IN{~i_reset}};
        for (int j = 0; j < N_OUT; j++) begin
            slot_free[j] = ~o_valid[j] | i_ready[j];
            take_out[j]  = (|gnt[j]) & slot_free[j];
            take_last[j] = i_last[gnt_idx[j]];
            o_ready      = o_ready | (gnt[j] & {N_IN{slot_free[j]}});
        end
        take_in = i_valid & o_ready;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < N_IN; k++) begin
                in_mode[k] <= IN_IDLE;
                in_dest[k] <= '0;
            end
            o_err <= 1'b0;
        end else begin
            for (int k = 0; k < N_IN; k++) begin
                if (take_in[k]) begin
                    if (i_last[k]) begin
                        in_mode[k] <= IN_IDLE;
                    end else begin
                        in_mode[k] <= drop_now[k] ? IN_DROP : IN_FWD;
                        in_dest[k] <= eff_dest[k];
                    end
                    if (drop_now[k]) begin
                        o_err <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid <= '0;
            o_data  <= '0;
            o_last  <= '0;
            o_src   <= '0;
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                if (slot_free[j]) begin
                    o_valid[j] <= take_out[j];
                    if (take_out[j]) begin
                        o_data[j*DATA_W +: DATA_W] <= i_data[int'(gnt_idx[j])*DATA_W +: DATA_W];
                        o_last[j]                  <= take_last[j];
                        o_src[j*SRC_W +: SRC_W]    <= gnt_idx[j];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sc_rr_xbar_nxm.sv
// tb/tb_sc_rr_xbar_nxm.sv - self-checking bench for sc_rr_xbar_nxm
module tb_sc_rr_xbar_nxm;

    localparam int N_IN   = 4;
    localparam int N_OUT  = 2;
    localparam int DATA_W = 8;
    localparam int DEST_W = 2;
    localparam int SRC_W  = 2;
    localparam int DROP   = 99;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  i_valid;
    logic [31:0] i_data;
    logic [7:0]  i_dest;
    logic [3:0]  i_last;
    logic [3:0]  o_ready;
    logic [1:0]  o_valid;
    logic [15:0] o_data;
    logic [1:0]  o_last;
    logic [3:0]  o_src;
    logic [1:0]  i_ready;
    logic        o_err;

    int n_checks = 0;
    int n_err    = 0;

    sc_rr_xbar_nxm #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .DATA_W (DATA_W),
        .DEST_W (DEST_W),
        .SRC_W  (SRC_W)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_dest  (i_dest),
        .i_last  (i_last),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_src   (o_src),
        .i_ready (i_ready),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: rr pointer, owner and per-input mode as plain integers.
    int          m_ptr  [2] = '{0, 0};
    int          m_own  [2] = '{-1, -1};
    int          m_mode [4] = '{-1, -1, -1, -1};
    bit          m_v    [2] = '{0, 0};
    logic [7:0]  m_d    [2] = '{8'h00, 8'h00};
    bit          m_l    [2] = '{0, 0};
    int          m_s    [2] = '{0, 0};
    bit          m_err      = 1'b0;
    bit          m_zero     = 1'b1;

    always @(negedge clk) begin : p_model
        int         dst  [4];
        bit         drp  [4];
        int         win  [2];
        bit         free [2];
        logic [3:0] rdy;
        int         k;
        int         w;

        for (int j = 0; j < N_OUT; j++) begin
            check($sformatf("model_o_valid%0d", j), 32'(o_valid[j]), 32'(m_v[j]));
            if (m_v[j]) begin
                check($sformatf("model_o_data%0d", j), 32'(o_data[j*8 +: 8]), 32'(m_d[j]));
                check($sformatf("model_o_last%0d", j), 32'(o_last[j]), 32'(m_l[j]));
                check($sformatf("model_o_src%0d", j), 32'(o_src[j*2 +: 2]), 32'(m_s[j]));
            end else if (m_zero) begin
                check($sformatf("reset_o_data%0d", j), 32'(o_data[j*8 +: 8]), 32'd0);
                check($sformatf("reset_o_last%0d", j), 32'(o_last[j]), 32'd0);
                check($sformatf("reset_o_src%0d", j), 32'(o_src[j*2 +: 2]), 32'd0);
            end
        end
        check("model_o_err", 32'(o_err), 32'(m_err));

        rdy = '0;
        for (int q = 0; q < N_IN; q++) begin
            dst[q] = (m_mode[q] >= 0 && m_mode[q] != DROP) ? m_mode[q] : int'(i_dest[q*2 +: 2]);
            drp[q] = (m_mode[q] == DROP) || (m_mode[q] < 0 && dst[q] >= N_OUT);
        end
        for (int j = 0; j < N_OUT; j++) begin
            free[j] = !m_v[j] || i_ready[j];
            win[j]  = -1;
            if (m_own[j] >= 0) begin
                if (i_valid[m_own[j]]) win[j] = m_own[j];
            end else begin
                for (int i = 0; i < N_IN; i++) begin
                    k = (m_ptr[j] + i) % N_IN;
                    if (win[j] < 0 && i_valid[k] && !drp[k] && dst[k] == j) win[j] = k;
                end
            end
            if (!free[j]) win[j] = -1;
            if (win[j] >= 0) rdy[win[j]] = 1'b1;
        end
        for (int q = 0; q < N_IN; q++) begin
            if (drp[q] && i_valid[q]) rdy[q] = 1'b1;
        end
        if (rst) rdy = '0;
        check("model_o_ready", 32'(o_ready), 32'(rdy));

        // Advance the model to the state the coming rising edge must produce.
        if (rst) begin
            for (int j = 0; j < N_OUT; j++) begin
                m_ptr[j] = 0; m_own[j] = -1; m_v[j] = 0; m_d[j] = 8'h00; m_l[j] = 0; m_s[j] = 0;
            end
            for (int q = 0; q < N_IN; q++) m_mode[q] = -1;
            m_err  = 1'b0;
            m_zero = 1'b1;
        end else begin
            m_zero = 1'b0;
            for (int j = 0; j < N_OUT; j++) begin
                if (free[j]) begin
                    m_v[j] = (win[j] >= 0);
                    if (win[j] >= 0) begin
                        w      = win[j];
                        m_d[j] = i_data[w*8 +: 8];
                        m_l[j] = i_last[w];
                        m_s[j] = w;
                        if (i_last[w]) begin
                            m_own[j]  = -1;
                            m_ptr[j]  = (w + 1) % N_IN;
                            m_mode[w] = -1;
                        end else begin
                            m_own[j]  = w;
                            m_mode[w] = j;
                        end
                    end
                end
            end
            for (int q = 0; q < N_IN; q++) begin
                if (drp[q] && i_valid[q]) begin
                    m_err     = 1'b1;
                    m_mode[q] = i_last[q] ? -1 : DROP;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input bit v, input logic [7:0] d, input int dst, input bit l);
        i_valid[k]        = v;
        i_data[k*8 +: 8]  = d;
        i_dest[k*2 +: 2]  = 2'(dst);
        i_last[k]         = l;
    endtask

    task automatic idle();
        i_valid = '0;
        i_last  = '0;
    endtask

    initial begin : p_stim
        logic [3:0] src_seq;
        rst     = 1'b1;
        i_valid = '0;
        i_data  = '0;
        i_dest  = '0;
        i_last  = '0;
        i_ready = 2'b11;

        // Reset with every input requesting out0.
        for (int k = 0; k < N_IN; k++) drive(k, 1'b1, 8'(8'hA0 + k), 0, 1'b1);
        repeat (3) begin
            tick();
            check("rst_o_ready", 32'(o_ready), 32'd0);
            check("rst_o_valid", 32'(o_valid), 32'd0);
            check("rst_o_err", 32'(o_err), 32'd0);
        end
        rst = 1'b0;
        #1 check("first_grant_in0", 32'(o_ready), 32'b0001);

        // Single-beat packets from all inputs rotate 0,1,2,3,0.
        for (int n = 0; n < 5; n++) begin
            tick();
            src_seq = 4'(n % 4);
            check("rr_o_src0", 32'(o_src[1:0]), 32'(src_seq));
            check("rr_o_valid0", 32'(o_valid[0]), 32'd1);
            check("rr_o_data0", 32'(o_data[7:0]), 32'(8'hA0 + src_seq));
        end
        idle();
        tick();
        tick();

        // 3-beat packet from in1 locks out1; in2 waits, then ptr[1]=2 favours in2.
        drive(1, 1'b1, 8'h11, 1, 1'b0);
        tick();
        check("pkt_beat1_data", 32'(o_data[15:8]), 32'h11);
        check("pkt_beat1_src", 32'(o_src[3:2]), 32'd1);
        drive(1, 1'b1, 8'h12, 0, 1'b0);
        drive(2, 1'b1, 8'h21, 1, 1'b1);
        #1 check("lock_blocks_in2", 32'(o_ready), 32'b0010);
        tick();
        check("pkt_beat2_data", 32'(o_data[15:8]), 32'h12);
        drive(1, 1'b1, 8'h13, 0, 1'b1);
        tick();
        check("pkt_beat3_data", 32'(o_data[15:8]), 32'h13);
        check("pkt_beat3_last", 32'(o_last[1]), 32'd1);
        drive(1, 1'b1, 8'h14, 1, 1'b1);
        #1 check("ptr1_is_2", 32'(o_ready), 32'b0100);
        tick();
        check("in2_after_pkt_src", 32'(o_src[3:2]), 32'd2);
        check("in2_after_pkt_data", 32'(o_data[15:8]), 32'h21);
        drive(2, 1'b0, 8'h00, 0, 1'b0);
        tick();
        check("in1_next_data", 32'(o_data[15:8]), 32'h14);
        idle();
        tick();

        // Parallel outputs, then stall out0 while out1 keeps flowing.
        drive(0, 1'b1, 8'h40, 0, 1'b1);
        drive(3, 1'b1, 8'h43, 1, 1'b1);
        tick();
        check("par_o_valid", 32'(o_valid), 32'b11);
        check("par_o_data", 32'(o_data), 32'h4340);
        check("par_o_src", 32'(o_src), 32'b1100);
        i_ready = 2'b10;
        drive(0, 1'b1, 8'h41, 0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            drive(3, 1'b1, 8'(8'h50 + c), 1, 1'b1);
            #1 check("stall_o_ready", 32'(o_ready), 32'b1000);
            tick();
            check("stall_o_data0", 32'(o_data[7:0]), 32'h40);
            check("stall_o_data1", 32'(o_data[15:8]), 32'(8'h50 + c));
        end
        i_ready = 2'b11;
        drive(3, 1'b0, 8'h00, 0, 1'b0);
        #1 check("unstall_o_ready", 32'(o_ready), 32'b0001);
        tick();
        check("unstall_o_data0", 32'(o_data[7:0]), 32'h41);
        idle();
        tick();

        // Illegal destination: 2 beats dropped, second with a legal-looking dest.
        drive(2, 1'b1, 8'h77, 3, 1'b0);
        #1 check("drop_o_ready1", 32'(o_ready), 32'b0100);
        check("drop_err_before", 32'(o_err), 32'd0);
        tick();
        check("drop_err_after", 32'(o_err), 32'd1);
        check("drop_no_valid1", 32'(o_valid), 32'd0);
        drive(2, 1'b1, 8'h78, 0, 1'b1);
        #1 check("drop_o_ready2", 32'(o_ready), 32'b0100);
        tick();
        check("drop_no_valid2", 32'(o_valid), 32'd0);
        idle();
        tick();

        // Reset in the middle of a packet flushes the locks.
        drive(0, 1'b1, 8'h61, 0, 1'b0);
        tick();
        check("flush_beat1", 32'(o_data[7:0]), 32'h61);
        drive(0, 1'b1, 8'h62, 0, 1'b0);
        rst = 1'b1;
        tick();
        check("flush_o_valid", 32'(o_valid), 32'd0);
        check("flush_o_err", 32'(o_err), 32'd0);
        rst = 1'b0;
        drive(0, 1'b0, 8'h00, 0, 1'b0);
        drive(1, 1'b1, 8'h70, 0, 1'b1);
        #1 check("flush_grant_in1", 32'(o_ready), 32'b0010);
        tick();
        check("flush_in1_src", 32'(o_src[1:0]), 32'd1);
        check("flush_in1_data", 32'(o_data[7:0]), 32'h70);
        idle();
        tick();

        // Mixed traffic cross-checked by the model only.
        for (int c = 0; c < 400; c++) begin
            i_valid = 4'($urandom);
            i_data  = $urandom;
            i_dest  = 8'($urandom);
            for (int k = 0; k < N_IN; k++) i_last[k] = ($urandom_range(0, 2) == 0);
            i_ready = 2'($urandom_range(0, 3) | $urandom_range(0, 3));
            rst     = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
